// File: rtl/conv_out_pool.sv
// conv_out_pool: ReLU + shift requantization with saturation, then optional 2x2/stride-2 max-pool on each of two channels
// Optional feature macro: POOL_EN (2x2 max-pool with pair register and line buffer); undefined -> requantized pass-through, latency 1.
// Ports: clk; Rst_n (synchronous, active-low); din1/din2 (signed 2M-bit) with valid_in1/valid_in2; filter_count (tag in);
//        dout1/dout2 (unsigned M-bit) with valid_o1/valid_o2 pulses; tag_o; frame_done (channel-1 last result of a frame).
module conv_out_pool #(
  parameter int M = 8,
  parameter int W = 480,
  parameter int SHIFT = 4
) (
  input  logic clk,
  input  logic Rst_n,
  input  logic [2*M-1:0] din1,
  input  logic [2*M-1:0] din2,
  input  logic valid_in1,
  input  logic valid_in2,
  input  logic [7:0] filter_count,
  output logic [M-1:0] dout1,
  output logic [M-1:0] dout2,
  output logic valid_o1,
  output logic valid_o2,
  output logic [7:0] tag_o,
  output logic frame_done
);
  localparam int CW = $clog2(W);
  logic [1:0] emit;
  logic [1:0][M-1:0] val;
  logic [1:0][7:0] tag;
  logic last0;
  // Negative sums clamp to zero; anything above M bits after the shift saturates.
  function automatic logic [M-1:0] quant(input logic [2*M-1:0] d);
    logic [2*M-1:0] s;
    s = d >> SHIFT;
    return d[2*M-1] ? '0 : (|s[2*M-1:M]) ? '1 : s[M-1:0];
  endfunction
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [2*M-1:0] d;
    logic v, adv, cl, rl;
    logic [CW-1:0] col, row;
    assign d = c == 0 ? din1 : din2;
    assign v = c == 0 ? valid_in1 : valid_in2;
    assign cl = col == CW'(W-1);
    assign rl = row == CW'(W-1);
    if (c == 0) begin : g_last
      assign last0 = cl & rl;
    end
    always_ff @(posedge clk)
      if (!Rst_n) begin
        col <= '0;
        row <= '0;
      end else if (adv) begin
        col <= cl ? '0 : col + 1'b1;
        row <= !cl ? row : rl ? '0 : row + 1'b1;
      end
`ifdef POOL_EN
    logic qv;
    logic [M-1:0] q, p, m, lb_rd;
    logic [7:0] qt;
    logic [M-1:0] lb [W/2];
    assign adv = qv;
    assign m = p > q ? p : q;
    assign lb_rd = lb[col[CW-1:1]];
    // A window completes on the odd column of an odd row.
    assign emit[c] = qv & row[0] & col[0];
    assign val[c] = m > lb_rd ? m : lb_rd;
    assign tag[c] = qt;
    always_ff @(posedge clk)
      if (!Rst_n) begin
        qv <= 1'b0;
        q <= '0;
        qt <= '0;
        p <= '0;
      end else begin
        qv <= v;
        if (v) begin
          q <= quant(d);
          qt <= filter_count;
        end
        if (qv && !col[0]) p <= q;
      end
    // Line buffer is never reset: each entry is rewritten on an even row before the odd row reads it.
    always_ff @(posedge clk)
      if (qv && !row[0] && col[0]) lb[col[CW-1:1]] <= m;
`else
    assign adv = v;
    assign emit[c] = v;
    assign val[c] = quant(d);
    assign tag[c] = filter_count;
`endif
  end
  always_ff @(posedge clk)
    if (!Rst_n) begin
      dout1 <= '0;
      dout2 <= '0;
      valid_o1 <= 1'b0;
      valid_o2 <= 1'b0;
      tag_o <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_o1 <= emit[0];
      valid_o2 <= emit[1];
      frame_done <= emit[0] & last0;
      if (emit[0]) dout1 <= val[0];
      if (emit[1]) dout2 <= val[1];
      tag_o <= emit[0] ? tag[0] : emit[1] ? tag[1] : tag_o;
    end
endmodule

// File: tb/tb_conv_out_pool.sv
// tb_conv_out_pool: directed self-checking bench for conv_out_pool (W=4; pass-through or POOL_EN build)
module tb_conv_out_pool;
  localparam int M = 8;
  localparam int W = 4;
`ifdef POOL_EN
  localparam int SH = 0;
`else
  localparam int SH = 4;
`endif
  typedef struct {
    int v1; int d1; int v2; int d2; int fc;
    int ev1; int e1; int ev2; int e2; int et; int efd;
  } vec_t;
  logic clk = 1'b0;
  logic Rst_n = 1'b0;
  logic [2*M-1:0] din1 = '0;
  logic [2*M-1:0] din2 = '0;
  logic valid_in1 = 1'b0;
  logic valid_in2 = 1'b0;
  logic [7:0] filter_count = '0;
  logic [M-1:0] dout1, dout2;
  logic valid_o1, valid_o2, frame_done;
  logic [7:0] tag_o;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int q1v[$], q1t[$], q1f[$], q1c[$], q2v[$];

  always #5 clk = ~clk;

  conv_out_pool #(.M(M), .W(W), .SHIFT(SH)) dut (
    .clk(clk), .Rst_n(Rst_n), .din1(din1), .din2(din2),
    .valid_in1(valid_in1), .valid_in2(valid_in2), .filter_count(filter_count),
    .dout1(dout1), .dout2(dout2), .valid_o1(valid_o1), .valid_o2(valid_o2),
    .tag_o(tag_o), .frame_done(frame_done)
  );

  always @(negedge clk) begin
    if (valid_o1) begin
      q1v.push_back(int'(dout1));
      q1t.push_back(int'(tag_o));
      q1f.push_back(int'(frame_done));
      q1c.push_back(cyc);
    end
    if (valid_o2) q2v.push_back(int'(dout2));
    if (frame_done) fd_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dout1"}, int'(dout1), 0);
    chk({nm, "_dout2"}, int'(dout2), 0);
    chk({nm, "_vo1"}, int'(valid_o1), 0);
    chk({nm, "_vo2"}, int'(valid_o2), 0);
    chk({nm, "_tag"}, int'(tag_o), 0);
    chk({nm, "_fd"}, int'(frame_done), 0);
  endtask

  task automatic idle(input int n);
    valid_in1 = 1'b0;
    valid_in2 = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    vec_t tv[19];
    int exp1[4];
    int exp2[4];
    int lat[$];
    int i1, i2, guard;
    exp1 = '{6, 8, 14, 16};
    exp2 = '{16, 14, 8, 6};
    Rst_n = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    Rst_n = 1'b1;
`ifndef POOL_EN
    tv[0]  = '{1, -5,     1, 'h0100, 3,  1, 'h00, 1, 'h10, 3,  0};
    tv[1]  = '{1, 'h0123, 0, 0,      4,  1, 'h12, 0, 'h10, 4,  0};
    tv[2]  = '{0, 0,      1, 'h7FFF, 5,  0, 'h12, 1, 'hFF, 5,  0};
    tv[3]  = '{1, 'h7FFF, 1, 'hFFFF, 6,  1, 'hFF, 1, 'h00, 6,  0};
    tv[4]  = '{1, 'h0FFF, 0, 0,      7,  1, 'hFF, 0, 'h00, 7,  0};
    tv[5]  = '{1, 'h1000, 0, 0,      8,  1, 'hFF, 0, 'h00, 8,  0};
    tv[6]  = '{1, 'h000F, 0, 0,      9,  1, 'h00, 0, 'h00, 9,  0};
    tv[7]  = '{1, 'h0010, 0, 0,      10, 1, 'h01, 0, 'h00, 10, 0};
    tv[8]  = '{0, 0,      0, 0,      11, 0, 'h01, 0, 'h00, 10, 0};
    tv[9]  = '{1, 'h8000, 0, 0,      12, 1, 'h00, 0, 'h00, 12, 0};
    tv[10] = '{1, 'h0AB0, 0, 0,      13, 1, 'hAB, 0, 'h00, 13, 0};
    tv[11] = '{1, 'h0050, 0, 0,      14, 1, 'h05, 0, 'h00, 14, 0};
    tv[12] = '{1, 'h0100, 0, 0,      15, 1, 'h10, 0, 'h00, 15, 0};
    tv[13] = '{1, 'h0200, 0, 0,      16, 1, 'h20, 0, 'h00, 16, 0};
    tv[14] = '{1, 'h0300, 0, 0,      17, 1, 'h30, 0, 'h00, 17, 0};
    tv[15] = '{1, 'h0400, 0, 0,      18, 1, 'h40, 0, 'h00, 18, 0};
    tv[16] = '{1, 'h0500, 0, 0,      19, 1, 'h50, 0, 'h00, 19, 0};
    tv[17] = '{1, 'h0600, 0, 0,      20, 1, 'h60, 0, 'h00, 20, 1};
    tv[18] = '{1, 'h0700, 0, 0,      21, 1, 'h70, 0, 'h00, 21, 0};
    for (int i = 0; i < 19; i++) begin
      valid_in1 = tv[i].v1[0];
      din1 = 16'(tv[i].d1);
      valid_in2 = tv[i].v2[0];
      din2 = 16'(tv[i].d2);
      filter_count = 8'(tv[i].fc);
      tick();
      chk($sformatf("v%0d_dout1", i), int'(dout1), tv[i].e1);
      chk($sformatf("v%0d_vo1", i), int'(valid_o1), tv[i].ev1);
      chk($sformatf("v%0d_dout2", i), int'(dout2), tv[i].e2);
      chk($sformatf("v%0d_vo2", i), int'(valid_o2), tv[i].ev2);
      chk($sformatf("v%0d_tag", i), int'(tag_o), tv[i].et);
      chk($sformatf("v%0d_fd", i), int'(frame_done), tv[i].efd);
    end
    for (int k = 0; k < 5; k++) begin
      valid_in1 = 1'b1;
      valid_in2 = 1'b0;
      din1 = 16'((k + 2) << 4);
      tick();
    end
    valid_in1 = 1'b0;
    Rst_n = 1'b0;
    tick();
    chk_zero("midreset");
    Rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      valid_in1 = 1'b1;
      din1 = 16'((k + 1) << 4);
      filter_count = 8'd7;
      tick();
      chk($sformatf("post_rst%0d_dout1", k), int'(dout1), k + 1);
      chk($sformatf("post_rst%0d_fd", k), int'(frame_done), k == 15 ? 1 : 0);
    end
    idle(2);
`else
    i1 = 0;
    i2 = 0;
    guard = 0;
    while ((i1 < 16 || i2 < 16) && guard < 2000) begin
      valid_in1 = i1 < 16 && $urandom_range(0, 2) != 0;
      valid_in2 = i2 < 16 && $urandom_range(0, 2) != 0;
      din1 = 16'(i1 + 1);
      din2 = 16'(16 - i2);
      filter_count = 8'd0;
      if (valid_in1 && (i1 == 5 || i1 == 7 || i1 == 13 || i1 == 15)) lat.push_back(cyc);
      if (valid_in1) i1++;
      if (valid_in2) i2++;
      guard++;
      tick();
    end
    chk("frameA_fed", i1 + i2, 32);
    for (int k = 0; k < 16; k++) begin
      valid_in1 = 1'b1;
      valid_in2 = 1'b0;
      din1 = 16'(k + 1);
      filter_count = 8'd1;
      if (k == 5 || k == 7 || k == 13 || k == 15) lat.push_back(cyc);
      tick();
    end
    idle(4);
    chk("pool_cnt1", q1v.size(), 8);
    chk("pool_cnt2", q2v.size(), 4);
    chk("pool_fd_cnt", fd_cnt, 2);
    for (int i = 0; i < 8 && i < q1v.size(); i++) begin
      chk($sformatf("pool1_%0d_val", i), q1v[i], exp1[i % 4]);
      chk($sformatf("pool1_%0d_tag", i), q1t[i], i / 4);
      chk($sformatf("pool1_%0d_fd", i), q1f[i], i % 4 == 3 ? 1 : 0);
      if (i < lat.size()) chk($sformatf("pool1_%0d_lat", i), q1c[i] - lat[i], 2);
    end
    for (int i = 0; i < 4 && i < q2v.size(); i++)
      chk($sformatf("pool2_%0d_val", i), q2v[i], exp2[i]);
    for (int k = 0; k < 6; k++) begin
      valid_in1 = 1'b1;
      valid_in2 = 1'b1;
      din1 = 16'(100 + k);
      din2 = 16'(200 + k);
      tick();
    end
    valid_in1 = 1'b0;
    valid_in2 = 1'b0;
    Rst_n = 1'b0;
    tick();
    chk_zero("midreset");
    Rst_n = 1'b1;
    q1v.delete();
    q1t.delete();
    q1f.delete();
    q1c.delete();
    q2v.delete();
    fd_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      valid_in1 = 1'b1;
      din1 = 16'(k + 1);
      filter_count = 8'd2;
      tick();
    end
    idle(4);
    chk("post_rst_cnt1", q1v.size(), 4);
    chk("post_rst_fd_cnt", fd_cnt, 1);
    chk("post_rst_cnt2", q2v.size(), 0);
    for (int i = 0; i < 4 && i < q1v.size(); i++) begin
      chk($sformatf("post_rst_%0d_val", i), q1v[i], exp1[i]);
      chk($sformatf("post_rst_%0d_tag", i), q1t[i], 2);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
